// File: rtl/wb_bus_mux_pkg.sv
// Shared definitions for the wishbone bus mux: region decode codes and
// debug port geometry.
package wb_bus_mux_pkg;

    typedef enum logic [1:0] {
        REGION_PROG    = 2'b00,
        REGION_PADS    = 2'b01,
        REGION_DEBUG   = 2'b10,
        REGION_ENTROPY = 2'b11
    } region_e;

    localparam int DEBUG_ADDR_W = 5;

endpackage

// File: rtl/wb_bus_mux_if.sv
// Wishbone-classic slave-side bundle between the management bus master
// and the bus mux.
interface wb_bus_mux_if #(
    parameter int WB_WIDTH = 32
);
    logic                wbs_stb_i;
    logic                wbs_cyc_i;
    logic                wbs_we_i;
    logic [WB_WIDTH-1:0] wbs_adr_i;
    logic [WB_WIDTH-1:0] wbs_dat_i;
    logic                wbs_ack_o;
    logic [WB_WIDTH-1:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_bus_mux_entropy_reg.sv
// Software entropy accumulator: each enabled cycle rotates the word left
// by one and folds in the supplied data with XOR.
module wb_entropy_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] word_o
);
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    always_comb begin
        // NOTE: default first so every path assigns word_d and no latch is inferred.
        word_d = word_q;
        if (en_i) begin
            word_d = {word_q[WIDTH-2:0], word_q[WIDTH-1]} ^ din_i;
        end
    end

    // NOTE: non-blocking assignment keeps register updates race-free between processes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;
endmodule

// File: rtl/wb_bus_mux.sv
// Wishbone-classic slave splitting the address space into program, pad,
// debug and entropy regions; writes become one-cycle strobes, reads are registered.
module wb_bus_mux
    import wb_bus_mux_pkg::*;
#(
    parameter int LOG_CORES   = 3,
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 16,
    parameter int IO_PINS     = 16,
    parameter int WB_WIDTH    = 32
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    wb_bus_mux_if.slave             wbs,

    output logic                    prog_we,
    output logic [LOG_CORES-1:0]    prog_sel,
    output logic [PC_WIDTH-1:0]     prog_waddr,
    output logic [INSTR_WIDTH-1:0]  prog_wdata,

    output logic                    pads_we,
    output logic                    pads_waddr,
    output logic [IO_PINS-1:0]      pads_wdata,

    output logic [LOG_CORES-1:0]    debug_sel,
    output logic [DEBUG_ADDR_W-1:0] debug_addr,
    output logic                    debug_we,
    output logic [DATA_WIDTH-1:0]   debug_wdata,
    input  logic [DATA_WIDTH-1:0]   debug_rdata,

    output logic [WB_WIDTH-1:0]     entropy_word
);
    region_e             region;
    logic                req;
    logic                entropy_en;
    logic                unused_adr;

    logic                ack_q,      ack_d;
    logic                prog_we_q,  prog_we_d;
    logic                pads_we_q,  pads_we_d;
    logic                debug_we_q, debug_we_d;
    logic [WB_WIDTH-1:0] dat_q,      dat_d;

    assign region = region_e'(wbs.wbs_adr_i[WB_WIDTH-1 -: 2]);
    assign req    = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q;

    assign prog_waddr  = wbs.wbs_adr_i[PC_WIDTH-1:0];
    assign prog_sel    = wbs.wbs_adr_i[PC_WIDTH+LOG_CORES-1:PC_WIDTH];
    assign prog_wdata  = wbs.wbs_dat_i[INSTR_WIDTH-1:0];
    assign pads_waddr  = wbs.wbs_adr_i[0];
    assign pads_wdata  = wbs.wbs_dat_i[IO_PINS-1:0];
    assign debug_addr  = wbs.wbs_adr_i[DEBUG_ADDR_W-1:0];
    assign debug_sel   = wbs.wbs_adr_i[DEBUG_ADDR_W+LOG_CORES-1:DEBUG_ADDR_W];
    assign debug_wdata = wbs.wbs_dat_i[DATA_WIDTH-1:0];

    // Address bits between the field decodes and the region bits are don't-care.
    assign unused_adr = ^wbs.wbs_adr_i;

    always_comb begin
        ack_d      = req;
        prog_we_d  = 1'b0;
        pads_we_d  = 1'b0;
        debug_we_d = 1'b0;
        entropy_en = 1'b0;
        dat_d      = dat_q;
        if (req) begin
            if (wbs.wbs_we_i) begin
                dat_d = '0;
                case (region)
                    REGION_PROG:    prog_we_d  = 1'b1;
                    REGION_PADS:    pads_we_d  = 1'b1;
                    REGION_DEBUG:   debug_we_d = 1'b1;
                    REGION_ENTROPY: entropy_en = 1'b1;
                endcase
            end else begin
                case (region)
                    REGION_DEBUG:   dat_d = WB_WIDTH'(debug_rdata);
                    REGION_ENTROPY: dat_d = entropy_word;
                    default:        dat_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q      <= 1'b0;
            prog_we_q  <= 1'b0;
            pads_we_q  <= 1'b0;
            debug_we_q <= 1'b0;
            dat_q      <= '0;
        end else begin
            ack_q      <= ack_d;
            prog_we_q  <= prog_we_d;
            pads_we_q  <= pads_we_d;
            debug_we_q <= debug_we_d;
            dat_q      <= dat_d;
        end
    end

    wb_entropy_reg #(
        .WIDTH (WB_WIDTH)
    ) u_entropy (
        .clk_i  (wb_clk_i),
        .rst_i  (wb_rst_i),
        .en_i   (entropy_en),
        .din_i  (wbs.wbs_dat_i),
        .word_o (entropy_word)
    );

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign prog_we       = prog_we_q;
    assign pads_we       = pads_we_q;
    assign debug_we      = debug_we_q;
endmodule

// File: tb/tb_wb_bus_mux.sv
// Directed self-checking bench for wb_bus_mux with hand-computed expectations.
module tb_wb_bus_mux;
    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        prog_we, pads_we, debug_we, pads_waddr;
    logic [2:0]  prog_sel, debug_sel;
    logic [7:0]  prog_waddr;
    logic [31:0] prog_wdata, entropy_word;
    logic [15:0] pads_wdata, debug_wdata, debug_rdata;
    logic [4:0]  debug_addr;

    int total = 0;
    int bad   = 0;

    wb_bus_mux_if #(.WB_WIDTH(32)) wb_if ();

    wb_bus_mux dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .wbs          (wb_if),
        .prog_we      (prog_we),
        .prog_sel     (prog_sel),
        .prog_waddr   (prog_waddr),
        .prog_wdata   (prog_wdata),
        .pads_we      (pads_we),
        .pads_waddr   (pads_waddr),
        .pads_wdata   (pads_wdata),
        .debug_sel    (debug_sel),
        .debug_addr   (debug_addr),
        .debug_we     (debug_we),
        .debug_wdata  (debug_wdata),
        .debug_rdata  (debug_rdata),
        .entropy_word (entropy_word)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        wb_if.wbs_cyc_i = 1'b1;
        wb_if.wbs_stb_i = 1'b1;
        wb_if.wbs_we_i  = we;
        wb_if.wbs_adr_i = adr;
        wb_if.wbs_dat_i = dat;
    endtask

    task automatic release_bus();
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_we_i  = 1'b0;
    endtask

    function automatic logic [31:0] strobes();
        return {29'd0, prog_we, pads_we, debug_we};
    endfunction

    initial begin
        wb_rst_i    = 1'b1;
        debug_rdata = 16'h0000;
        wb_if.wbs_adr_i = '0;
        wb_if.wbs_dat_i = '0;
        release_bus();
        repeat (3) tick();
        wb_rst_i = 1'b0;
        tick();
        check("rst_ack",     {31'd0, wb_if.wbs_ack_o}, 32'd0);
        check("rst_strobes", strobes(), 32'd0);
        check("rst_dat",     wb_if.wbs_dat_o, 32'd0);
        check("rst_entropy", entropy_word, 32'd0);

        // prog read: acked, no strobe, reads as zero
        drive(1'b0, 32'h0000_05DB, 32'h0);
        check("prog_rd_preack", {31'd0, wb_if.wbs_ack_o}, 32'd0);
        tick();
        check("prog_rd_ack", {31'd0, wb_if.wbs_ack_o}, 32'd1);
        check("prog_rd_strobes", strobes(), 32'd0);
        check("prog_rd_dat", wb_if.wbs_dat_o, 32'd0);
        release_bus();
        tick();
        check("prog_rd_ack_drop", {31'd0, wb_if.wbs_ack_o}, 32'd0);

        // prog write
        drive(1'b1, 32'h0000_05DB, 32'hFFFF_FFFF);
        tick();
        check("prog_wr_ack", {31'd0, wb_if.wbs_ack_o}, 32'd1);
        check("prog_wr_strobes", strobes(), 32'b100);
        check("prog_sel", {29'd0, prog_sel}, 32'd5);
        check("prog_waddr", {24'd0, prog_waddr}, 32'hDB);
        check("prog_wdata", prog_wdata, 32'hFFFF_FFFF);
        release_bus();
        tick();
        check("prog_wr_strobe_drop", strobes(), 32'd0);

        // pads write then read
        drive(1'b1, 32'h4000_0001, 32'hFFFF_FFFF);
        tick();
        check("pads_wr_strobes", strobes(), 32'b010);
        check("pads_waddr", {31'd0, pads_waddr}, 32'd1);
        check("pads_wdata", {16'd0, pads_wdata}, 32'h0000_FFFF);
        release_bus();
        tick();
        check("pads_wr_strobe_drop", strobes(), 32'd0);
        drive(1'b0, 32'h4000_0001, 32'h0);
        tick();
        check("pads_rd_ack", {31'd0, wb_if.wbs_ack_o}, 32'd1);
        check("pads_rd_strobes", strobes(), 32'd0);
        check("pads_rd_dat", wb_if.wbs_dat_o, 32'd0);
        release_bus();
        tick();

        // debug read then write
        debug_rdata = 16'hF0AA;
        drive(1'b0, 32'h8000_004A, 32'h0);
        tick();
        check("dbg_rd_ack", {31'd0, wb_if.wbs_ack_o}, 32'd1);
        check("debug_sel", {29'd0, debug_sel}, 32'd2);
        check("debug_addr", {27'd0, debug_addr}, 32'h0A);
        check("dbg_rd_dat", wb_if.wbs_dat_o, 32'h0000_F0AA);
        check("dbg_rd_strobes", strobes(), 32'd0);
        release_bus();
        debug_rdata = 16'h1234;
        tick();
        check("dbg_rd_dat_hold", wb_if.wbs_dat_o, 32'h0000_F0AA);
        drive(1'b1, 32'h8000_004A, 32'hFFFF_FFFF);
        tick();
        check("dbg_wr_strobes", strobes(), 32'b001);
        check("debug_wdata", {16'd0, debug_wdata}, 32'h0000_FFFF);
        check("dbg_wr_dat_zero", wb_if.wbs_dat_o, 32'd0);
        release_bus();
        tick();
        check("dbg_wr_strobe_drop", strobes(), 32'd0);

        // entropy accumulator: rotl1 then xor
        drive(1'b1, 32'hC000_0000, 32'hFFFF_FFFF);
        tick();
        check("ent_wr1", entropy_word, 32'hFFFF_FFFF);
        check("ent_wr1_strobes", strobes(), 32'd0);
        release_bus();
        tick();
        drive(1'b1, 32'hC000_0000, 32'hFFFF_FFFF);
        tick();
        check("ent_wr2", entropy_word, 32'h0000_0000);
        release_bus();
        tick();
        drive(1'b1, 32'hC000_0000, 32'h0000_0001);
        tick();
        check("ent_wr3", entropy_word, 32'h0000_0001);
        release_bus();
        tick();
        drive(1'b0, 32'hC000_0000, 32'hFFFF_FFFF);
        tick();
        check("ent_rd_dat", wb_if.wbs_dat_o, 32'h0000_0001);
        check("ent_rd_word", entropy_word, 32'h0000_0001);
        check("ent_rd_strobes", strobes(), 32'd0);
        release_bus();
        tick();
        drive(1'b1, 32'hC000_0000, 32'h8000_0000);
        tick();
        check("ent_wr4", entropy_word, 32'h8000_0002);
        release_bus();
        tick();
        drive(1'b1, 32'hC000_0000, 32'h0000_0000);
        tick();
        check("ent_wr5_wrap", entropy_word, 32'h0000_0005);
        release_bus();
        tick();
        drive(1'b0, 32'hC000_0000, 32'h0);
        tick();
        check("ent_rd2_dat", wb_if.wbs_dat_o, 32'h0000_0005);
        release_bus();
        tick();

        // stb or cyc alone is not a request
        drive(1'b1, 32'hC000_0000, 32'hFFFF_FFFF);
        wb_if.wbs_cyc_i = 1'b0;
        tick();
        tick();
        check("nocyc_ack", {31'd0, wb_if.wbs_ack_o}, 32'd0);
        check("nocyc_entropy", entropy_word, 32'h0000_0005);
        wb_if.wbs_cyc_i = 1'b1;
        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_adr_i = 32'h0000_0000;
        tick();
        tick();
        check("nostb_ack", {31'd0, wb_if.wbs_ack_o}, 32'd0);
        check("nostb_strobes", strobes(), 32'd0);
        release_bus();

        // stb held: ack 1,0,1
        drive(1'b0, 32'hC000_0000, 32'h0);
        tick();
        check("b2b_ack0", {31'd0, wb_if.wbs_ack_o}, 32'd1);
        tick();
        check("b2b_ack1", {31'd0, wb_if.wbs_ack_o}, 32'd0);
        tick();
        check("b2b_ack2", {31'd0, wb_if.wbs_ack_o}, 32'd1);
        release_bus();
        tick();

        // reset during a request cycle cancels it
        drive(1'b1, 32'hC000_0000, 32'h1234_5678);
        wb_rst_i = 1'b1;
        tick();
        check("rstreq_ack", {31'd0, wb_if.wbs_ack_o}, 32'd0);
        check("rstreq_strobes", strobes(), 32'd0);
        check("rstreq_dat", wb_if.wbs_dat_o, 32'd0);
        check("rstreq_entropy", entropy_word, 32'd0);
        release_bus();
        wb_rst_i = 1'b0;
        tick();
        check("rstreq_ack_after", {31'd0, wb_if.wbs_ack_o}, 32'd0);
        drive(1'b1, 32'hC000_0000, 32'h0000_0003);
        tick();
        check("reissue_ack", {31'd0, wb_if.wbs_ack_o}, 32'd1);
        check("reissue_entropy", entropy_word, 32'h0000_0003);
        release_bus();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
